fifo_wr_ptr_full: RTL and testbench
===================================

# fifo_wr_ptr_full

Write-domain pointer and status controller for the asynchronous FIFO, directly upstream of the FIFO memory controller. It accepts write requests from the producer and gates them into the memory write enable. It generates the binary write address and a Gray-coded write pointer for the read-domain synchronizer. From the synchronized read pointer it derives full, almost-full, fill level and a sticky overflow flag.

## Interface
Parameters:
- ADDRESS_WIDTH, 3, memory address width; pointer width is ADDRESS_WIDTH+1.
- FIFO_DEPTH, 8, must equal 2**ADDRESS_WIDTH.
- ALMOST_FULL_THR, 6, W_ALMOST_FULL asserts when W_LEVEL >= this value; legal range 1..FIFO_DEPTH.

Ports:
- W_CLK, input, 1, write-domain clock. One clock; all state is on the rising edge.
- W_RST, input, 1, asynchronous, active-low reset.
- W_INC, input, 1, producer write request, one word per cycle.
- R2W_GRAY_PTR, input, ADDRESS_WIDTH+1, read pointer in Gray code, already double-synchronized into W_CLK.
- OVF_CLR, input, 1, synchronous clear of W_OVF.
- WR_EN, output, 1, write enable to the memory. WR_EN = W_INC & ~W_FULL, combinational.
- W_ADDR, output, ADDRESS_WIDTH, memory write address. It is the low bits of the registered binary pointer.
- W_GRAY_PTR, output, ADDRESS_WIDTH+1, registered Gray write pointer, sent to the read-domain synchronizer.
- W_FULL, output, 1, registered full flag.
- W_ALMOST_FULL, output, 1, registered.
- W_LEVEL, output, ADDRESS_WIDTH+1, registered occupancy estimate, 0..FIFO_DEPTH.
- W_OVF, output, 1, sticky flag: a write was attempted while full.

## Operation
- Binary pointer W_BIN, ADDRESS_WIDTH+1 bits:
  - W_BIN_NEXT = W_BIN + WR_EN, modulo 2**(ADDRESS_WIDTH+1); natural wrap.
  - W_GRAY_NEXT = W_BIN_NEXT ^ (W_BIN_NEXT >> 1).
- Full: W_FULL <= (W_GRAY_NEXT == {~R2W_GRAY_PTR[MSB:MSB-1], R2W_GRAY_PTR[MSB-2:0]}).
  - This is the top-two-bits-inverted Gray compare.
  - For ADDRESS_WIDTH=1 the whole 2-bit pointer is inverted.
- Level:
  - R_BIN_SYNC = gray2bin(R2W_GRAY_PTR).
  - W_LEVEL <= W_BIN_NEXT - R_BIN_SYNC, modulo 2**(ADDRESS_WIDTH+1). The result is never greater than FIFO_DEPTH.
- W_ALMOST_FULL <= (level_next >= ALMOST_FULL_THR), where level_next is the value being loaded into W_LEVEL.
- Overflow:
  - W_OVF sets when W_INC & W_FULL.
  - It clears only on OVF_CLR or reset.
  - If set and clear occur in the same cycle, set wins.
- Writes while full are dropped: pointer holds and WR_EN stays low.
- The synchronized read pointer lags, so full and level are pessimistic. Deassertion is late by the synchronizer latency; assertion is never late.
- Reset (W_RST low, asynchronous): W_BIN=0, W_GRAY_PTR=0, W_FULL=0, W_ALMOST_FULL=0, W_LEVEL=0, W_OVF=0.
  - W_ADDR is 0 and WR_EN is 0 whenever W_FULL=0 and W_INC=0.
  - Reset mid-fill discards the pointer immediately. The read side must be reset in the same window.
- No state machine: registered pointer, flags and sticky bit only.

## Timing
- WR_EN is combinational from W_INC in the same cycle.
- The memory captures the data at edge N, at address W_ADDR valid before edge N.
- W_ADDR, W_GRAY_PTR, W_LEVEL and W_FULL update at the same edge N.
- W_FULL is high in the cycle after the write that fills the FIFO. There is no extra cycle of lag, so a back-to-back write can never overflow.
- A change on R2W_GRAY_PTR affects W_FULL, W_LEVEL and W_ALMOST_FULL one edge later.
- Only one Gray bit of W_GRAY_PTR changes per edge; this is required for CDC.
- Simultaneous write and read-pointer advance at the full boundary:
  - The comparison uses the new read pointer and W_GRAY_NEXT.
  - Result: full stays 0 if a slot was freed.

## Structure
- Shared FIFO package/header holds:
  - the PTR_WIDTH = ADDRESS_WIDTH+1 constant;
  - bin2gray and gray2bin functions, reused by the read-pointer block and the synchronizer checks.
- One sub-module, fifo_gray2bin: parameterized XOR-prefix converter used for R_BIN_SYNC. It is shared with the read-side empty/level logic.
- Pointer, full, level and overflow logic live at the top level.

## Test plan
- Reset with W_RST=0 mid-cycle, W_INC=1 -> all outputs 0 immediately; WR_EN=1 since not full; after release the first write goes to W_ADDR=0.
- Eight consecutive writes with R2W_GRAY_PTR=4'b0000:
  - W_FULL=1 after the 8th edge.
  - W_BIN=8, W_GRAY_PTR=4'b1100, W_ADDR=0, W_LEVEL=8.
  - W_ALMOST_FULL rose after the 6th write.
- Ninth write while full -> WR_EN=0, W_GRAY_PTR held at 4'b1100, W_OVF=1.
  - OVF_CLR then clears it.
  - OVF_CLR together with W_INC while full keeps W_OVF=1.
- From full, set R2W_GRAY_PTR=4'b0001 (read pointer 1) -> next edge W_FULL=0 and W_LEVEL=7.
  - A same-cycle write refills: W_FULL=1 and W_GRAY_PTR=gray(9)=4'b1101.
- Streaming 20 writes with the read pointer tracking 2 behind:
  - the pointer wraps 15 to 0;
  - W_GRAY_PTR changes one bit per edge;
  - W_LEVEL stays 2; W_FULL never asserts.
- Assert async reset while W_LEVEL=5 -> all outputs clear without a clock edge, and W_GRAY_PTR returns to 0.

Source files
------------

// File: rtl/fifo_wr_ptr_full_pkg.sv
// Shared async-FIFO definitions: pointer width and Gray/binary conversion helpers
// used by the write-pointer, read-pointer and synchronizer-check blocks.
package fifo_wr_ptr_full_pkg;

    localparam int ADDRESS_WIDTH_DEF = 3;
    localparam int PTR_WIDTH         = ADDRESS_WIDTH_DEF + 1;

    // Helpers run on a wide vector so any pointer width up to 16 can share them;
    // callers zero-extend into the helper and truncate the result.
    localparam int MAX_PTR_WIDTH = 16;
    typedef logic [MAX_PTR_WIDTH-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin = '0;
        bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
        for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ptr_full_gray2bin.sv
// XOR-prefix Gray-to-binary converter, shared with the read-side empty/level logic.
module fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the parity of all Gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^(i_gray >> i);
    end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Write-domain pointer/status controller for the async FIFO: gated write enable,
// binary address, Gray pointer for the CDC, and full/almost-full/level/overflow.
module fifo_wr_ptr_full
    import fifo_wr_ptr_full_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 3,
    parameter int FIFO_DEPTH      = 8,
    parameter int ALMOST_FULL_THR = 6
) (
    input  logic                     i_w_clk,
    input  logic                     i_w_rst_n,
    input  logic                     i_w_inc,
    input  logic [ADDRESS_WIDTH:0]   i_r2w_gray_ptr,
    input  logic                     i_ovf_clr,
    output logic                     o_wr_en,
    output logic [ADDRESS_WIDTH-1:0] o_w_addr,
    output logic [ADDRESS_WIDTH:0]   o_w_gray_ptr,
    output logic                     o_w_full,
    output logic                     o_w_almost_full,
    output logic [ADDRESS_WIDTH:0]   o_w_level,
    output logic                     o_w_ovf
);

    localparam int PW = ADDRESS_WIDTH + 1;

    // Full when the next write pointer equals the read pointer with its top two
    // Gray bits inverted; for a 2-bit pointer this inverts the whole pointer.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    localparam int AF_THR_CLAMP = (ALMOST_FULL_THR > FIFO_DEPTH) ? FIFO_DEPTH : ALMOST_FULL_THR;
    localparam logic [PW:0] AF_THR = (PW + 1)'(AF_THR_CLAMP);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_level;
    logic          r_ovf;

    logic          w_wr_en;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_rbin_sync;
    logic [PW-1:0] w_level_next;
    logic          w_full_next;
    logic          w_almost_full_next;
    logic          w_ovf_next;

    fifo_gray2bin #(
        .WIDTH (PW)
    ) u_rptr_gray2bin (
        .i_gray (i_r2w_gray_ptr),
        .o_bin  (w_rbin_sync)
    );

    assign w_wr_en     = i_w_inc & ~r_full;
    assign w_bin_next  = r_bin + {{(PW-1){1'b0}}, w_wr_en};
    assign w_gray_next = PW'(bin2gray(ptr_max_t'(w_bin_next)));

    // Uses the read pointer as it is now, so a slot freed in the same cycle as
    // a write keeps full low; a lagging read pointer only makes this pessimistic.
    assign w_full_next        = (w_gray_next == (i_r2w_gray_ptr ^ FULL_MASK));
    assign w_level_next       = w_bin_next - w_rbin_sync;
    assign w_almost_full_next = ({1'b0, w_level_next} >= AF_THR);

    // A set in the same cycle as a clear wins.
    assign w_ovf_next = (i_w_inc & r_full) | (r_ovf & ~i_ovf_clr);

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            r_bin         <= '0;
            r_gray        <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_bin         <= w_bin_next;
            r_gray        <= w_gray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
            r_level       <= w_level_next;
            r_ovf         <= w_ovf_next;
        end
    end

    assign o_wr_en         = w_wr_en;
    assign o_w_addr        = r_bin[ADDRESS_WIDTH-1:0];
    assign o_w_gray_ptr    = r_gray;
    assign o_w_full        = r_full;
    assign o_w_almost_full = r_almost_full;
    assign o_w_level       = r_level;
    assign o_w_ovf         = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Directed bench for fifo_wr_ptr_full: expected post-edge state is queued per step
// from a write/read count model and popped for comparison after the edge.
module tb_fifo_wr_ptr_full;

    logic       clk;
    logic       rst_n;
    logic       inc;
    logic [3:0] r2w_gray;
    logic       ovf_clr;
    logic       wr_en;
    logic [2:0] w_addr;
    logic [3:0] w_gray;
    logic       w_full;
    logic       w_af;
    logic [3:0] w_level;
    logic       w_ovf;

    fifo_wr_ptr_full #(
        .ADDRESS_WIDTH   (3),
        .FIFO_DEPTH      (8),
        .ALMOST_FULL_THR (6)
    ) dut (
        .i_w_clk         (clk),
        .i_w_rst_n       (rst_n),
        .i_w_inc         (inc),
        .i_r2w_gray_ptr  (r2w_gray),
        .i_ovf_clr       (ovf_clr),
        .o_wr_en         (wr_en),
        .o_w_addr        (w_addr),
        .o_w_gray_ptr    (w_gray),
        .o_w_full        (w_full),
        .o_w_almost_full (w_af),
        .o_w_level       (w_level),
        .o_w_ovf         (w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] addr;
        logic [3:0] gray;
        logic       full;
        logic       af;
        logic [3:0] level;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];

    int n_pass  = 0;
    int n_total = 0;

    // Model: absolute counts of accepted writes and of reads seen by the write side.
    int   m_wr   = 0;
    int   m_rd   = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(w_addr),  0);
        chk({tag, "_gray"},  32'(w_gray),  0);
        chk({tag, "_full"},  32'(w_full),  0);
        chk({tag, "_af"},    32'(w_af),    0);
        chk({tag, "_level"}, 32'(w_level), 0);
        chk({tag, "_ovf"},   32'(w_ovf),   0);
    endtask

    // One clock of stimulus: drive, check combinational WR_EN, queue the expected
    // post-edge state, clock, then pop and compare.
    task automatic step(input string tag, input logic s_inc, input int s_rd, input logic s_clr);
        logic e_wr_en;
        int   lvl;
        exp_t e;
        exp_t got;
        inc      = s_inc;
        ovf_clr  = s_clr;
        r2w_gray = gray4(s_rd);
        #1;
        e_wr_en = s_inc & ~m_full;
        chk({tag, "_wr_en"}, 32'(wr_en), 32'(e_wr_en));
        chk({tag, "_addr_pre"}, 32'(w_addr), 32'(m_wr % 8));

        m_ovf = (s_inc & m_full) | (m_ovf & ~s_clr);
        if (e_wr_en) m_wr++;
        m_rd   = s_rd;
        lvl    = m_wr - m_rd;
        m_full = (lvl == 8);
        e.addr  = 3'(m_wr % 8);
        e.gray  = gray4(m_wr);
        e.full  = m_full;
        e.af    = (lvl >= 6);
        e.level = 4'(lvl);
        e.ovf   = m_ovf;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, "_addr"},  32'(w_addr),  32'(got.addr));
        chk({tag, "_gray"},  32'(w_gray),  32'(got.gray));
        chk({tag, "_full"},  32'(w_full),  32'(got.full));
        chk({tag, "_af"},    32'(w_af),    32'(got.af));
        chk({tag, "_level"}, 32'(w_level), 32'(got.level));
        chk({tag, "_ovf"},   32'(w_ovf),   32'(got.ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] prev_gray;
        int         ones;

        rst_n    = 1'b1;
        inc      = 1'b0;
        r2w_gray = 4'b0000;
        ovf_clr  = 1'b0;

        // Asynchronous reset asserted mid-cycle with a write request pending.
        @(posedge clk);
        #2;
        inc   = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        chk("rst_wr_en", 32'(wr_en), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        inc   = 1'b0;

        // Fill with read pointer parked at 0.
        for (int i = 0; i < 8; i++) step("fill", 1'b1, 0, 1'b0);
        chk("fill_gray_1100", 32'(w_gray), 32'h0000000c);
        chk("fill_level_8", 32'(w_level), 8);
        chk("fill_full", 32'(w_full), 1);

        // Writes while full are dropped and flagged.
        step("ovf_set", 1'b1, 0, 1'b0);
        chk("ovf_gray_held", 32'(w_gray), 32'h0000000c);
        step("ovf_clr", 1'b0, 0, 1'b1);
        step("ovf_clr_vs_set", 1'b1, 0, 1'b1);
        chk("ovf_set_wins", 32'(w_ovf), 1);
        step("ovf_clr2", 1'b0, 0, 1'b1);

        // Read pointer advances one slot, then a write refills.
        step("rd_free", 1'b0, 1, 1'b0);
        chk("rd_free_level_7", 32'(w_level), 7);
        step("refill", 1'b1, 1, 1'b0);
        chk("refill_gray_1101", 32'(w_gray), 32'h0000000d);

        // Drain to level 2, then stream 20 writes with the read side 2 behind.
        step("drain", 1'b0, 7, 1'b0);
        for (int i = 0; i < 20; i++) begin
            prev_gray = w_gray;
            step("stream", 1'b1, m_wr - 1, 1'b0);
            ones = $countones(prev_gray ^ w_gray);
            chk("stream_gray_one_bit", 32'(ones), 1);
        end

        // Reach level 5, then reset asynchronously between edges.
        step("pre_rst", 1'b1, m_wr - 4, 1'b0);
        chk("pre_rst_level_5", 32'(w_level), 5);
        inc = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        chk("rst_mid_wr_en", 32'(wr_en), 0);
        m_wr   = 0;
        m_rd   = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", 1'b1, 0, 1'b0);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
